formation_ctrl: RTL and testbench

FORMATION_CTRL -- requirements
Module: formation_ctrl

---
 rtl/formation_pkg.sv | 21 ++
 rtl/axis_accum.sv | 47 ++++
 rtl/formation_ctrl.sv | 155 +++++++++++++++
 tb/tb_formation_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/formation_pkg.sv
// Shared types and fixed-point constants for the invader formation controller.
package formation_pkg;

    localparam int FRAC_BITS = 6;
    localparam int ACC_W     = 18;
    localparam int POS_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_R,
        ST_DROP_L,
        ST_MOVE_L,
        ST_DROP_R,
        ST_LANDED
    } state_e;

    function automatic logic signed [ACC_W-1:0] to_fp(input int pix);
        return ACC_W'(pix <<< FRAC_BITS);
    endfunction

endpackage

// File: rtl/axis_accum.sv
// Signed fixed-point accumulator for one axis: synchronous load, enabled add,
// result clamped into [min_i, max_i].
module axis_accum
    import formation_pkg::*;
#(
    parameter logic signed [ACC_W-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    load_i,
    input  logic signed [ACC_W-1:0] load_val_i,
    input  logic                    add_i,
    input  logic signed [ACC_W-1:0] delta_i,
    input  logic signed [ACC_W-1:0] min_i,
    input  logic signed [ACC_W-1:0] max_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   lo;
    logic signed [ACC_W:0]   hi;

    // One guard bit so an overshoot is caught before it can wrap.
    always_comb begin
        sum   = {acc_q[ACC_W-1], acc_q} + {delta_i[ACC_W-1], delta_i};
        lo    = {min_i[ACC_W-1], min_i};
        hi    = {max_i[ACC_W-1], max_i};
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (add_i) begin
            if (sum < lo)      acc_d = min_i;
            else if (sum > hi) acc_d = max_i;
            else               acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) acc_q <= RESET_VAL;
        else         acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/formation_ctrl.sv
// Invader formation motion: sweeps right/left between bounds, drops a row at
// each wall or on request, and stops when the formation reaches the floor.
module formation_ctrl
    import formation_pkg::*;
#(
    parameter int  INIT_X       = 20,
    parameter int  INIT_Y       = 20,
    parameter int  LEFT_BOUND   = 0,
    parameter int  RIGHT_BOUND  = 600,
    parameter int  FLOOR_Y      = 400,
    parameter int  X_STEP       = 80,
    parameter int  Y_STEP       = 64,
    parameter int  DROP_PIX     = 16,
    parameter int  SPEED_LEVELS = 4,
    localparam int LVL_W        = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             start,
    input  logic             enable,
    input  logic             speedUp,
    input  logic             chgDir,
    input  logic             restart,
    output logic [POS_W-1:0] topLeftX,
    output logic [POS_W-1:0] topLeftY,
    output logic             dirRight,
    output logic [LVL_W-1:0] speedLevel,
    output logic             landed
);

    localparam logic signed [ACC_W-1:0] X_INIT_FP = to_fp(INIT_X);
    localparam logic signed [ACC_W-1:0] Y_INIT_FP = to_fp(INIT_Y);
    localparam logic signed [ACC_W-1:0] LEFT_FP   = to_fp(LEFT_BOUND);
    localparam logic signed [ACC_W-1:0] RIGHT_FP  = to_fp(RIGHT_BOUND);
    localparam logic signed [ACC_W-1:0] FLOOR_FP  = to_fp(FLOOR_Y);
    localparam logic signed [ACC_W-1:0] DROP_FP   = to_fp(DROP_PIX);
    localparam logic signed [ACC_W-1:0] Y_STEP_FP = ACC_W'(Y_STEP);
    localparam logic signed [ACC_W-1:0] Y_MIN     = '0;
    localparam logic signed [ACC_W-1:0] Y_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [LVL_W-1:0]        MAX_LVL   = LVL_W'(SPEED_LEVELS - 1);

    state_e                  state_q;
    logic [LVL_W-1:0]        level_q;
    logic signed [ACC_W-1:0] cnt_q;
    logic                    dir_q;
    logic                    landed_q;

    logic signed [ACC_W-1:0] x_acc;
    logic signed [ACC_W-1:0] y_acc;
    logic signed [ACC_W-1:0] x_step;
    logic signed [ACC_W-1:0] x_delta;
    logic signed [ACC_W-1:0] y_load_val;
    logic                    frame_en;
    logic                    in_drop;
    logic                    drop_done;
    logic                    landing;
    logic                    x_add;
    logic                    y_add;
    logic                    y_load;

    // Motion follows the current (pre-transition) state, so a frame pulse that
    // coincides with a transition still moves the formation the old way.
    always_comb begin
        frame_en   = startOfFrame & enable;
        in_drop    = (state_q == ST_DROP_L) || (state_q == ST_DROP_R);
        drop_done  = (cnt_q >= DROP_FP);
        landing    = enable && (state_q != ST_IDLE) && (state_q != ST_LANDED)
                     && (y_acc >= FLOOR_FP);
        x_step     = ACC_W'(X_STEP * (int'(level_q) + 1));
        x_delta    = (state_q == ST_MOVE_L) ? -x_step : x_step;
        x_add      = !restart && frame_en
                     && ((state_q == ST_MOVE_R) || (state_q == ST_MOVE_L));
        y_add      = !restart && frame_en && in_drop && !drop_done;
        y_load     = restart || (enable && in_drop && drop_done && !landing);
        // Row start is recovered from the counter, which tracks Y since the drop began.
        y_load_val = restart ? Y_INIT_FP : (y_acc - cnt_q + DROP_FP);
    end

    axis_accum #(.RESET_VAL(X_INIT_FP)) u_x_accum (
        .clk       (clk),
        .resetN    (resetN),
        .load_i    (restart),
        .load_val_i(X_INIT_FP),
        .add_i     (x_add),
        .delta_i   (x_delta),
        .min_i     (LEFT_FP),
        .max_i     (RIGHT_FP),
        .acc_o     (x_acc)
    );

    axis_accum #(.RESET_VAL(Y_INIT_FP)) u_y_accum (
        .clk       (clk),
        .resetN    (resetN),
        .load_i    (y_load),
        .load_val_i(y_load_val),
        .add_i     (y_add),
        .delta_i   (Y_STEP_FP),
        .min_i     (Y_MIN),
        .max_i     (Y_MAX),
        .acc_o     (y_acc)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            landed_q <= 1'b0;
        end else if (restart) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            landed_q <= 1'b0;
        end else begin
            if (speedUp && (level_q != MAX_LVL))
                level_q <= level_q + 1'b1;
            if (landing) begin
                state_q  <= ST_LANDED;
                landed_q <= 1'b1;
            end else if (enable) begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        state_q <= ST_MOVE_R;
                        dir_q   <= 1'b1;
                    end
                    ST_MOVE_R: if ((x_acc >= RIGHT_FP) || chgDir)
                        state_q <= ST_DROP_L;
                    ST_MOVE_L: if ((x_acc <= LEFT_FP) || chgDir)
                        state_q <= ST_DROP_R;
                    ST_DROP_L, ST_DROP_R: begin
                        if (drop_done) begin
                            cnt_q   <= '0;
                            state_q <= (state_q == ST_DROP_L) ? ST_MOVE_L : ST_MOVE_R;
                            dir_q   <= (state_q == ST_DROP_R);
                        end else if (startOfFrame) begin
                            cnt_q <= cnt_q + Y_STEP_FP;
                        end
                    end
                    ST_LANDED: state_q <= ST_LANDED;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign topLeftX   = x_acc[FRAC_BITS +: POS_W];
    assign topLeftY   = y_acc[FRAC_BITS +: POS_W];
    assign dirRight   = dir_q;
    assign speedLevel = level_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_formation_ctrl.sv
// Randomized and directed check of formation_ctrl against a pixel-level model.
module tb_formation_ctrl;

    localparam int INIT_X = 20, INIT_Y = 20, LB = 0, RB = 600, FLOOR_Y = 400;
    localparam int X_STEP = 80, Y_STEP = 64, DROP_PIX = 16, SPEED_LEVELS = 4;

    typedef enum {M_IDLE, M_MR, M_DL, M_ML, M_DR, M_LAND} mstate_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0, start = 1'b0, enable = 1'b0;
    logic        speedUp = 1'b0, chgDir = 1'b0, restart = 1'b0;
    logic [10:0] topLeftX, topLeftY;
    logic        dirRight, landed;
    logic [1:0]  speedLevel;

    int      tests = 0, fails = 0;
    bit      chk_on = 1'b0;
    mstate_t m_st;
    int      m_x, m_y, m_cnt, m_lvl;
    bit      m_dir, m_land;

    formation_ctrl #(
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .LEFT_BOUND(LB), .RIGHT_BOUND(RB),
        .FLOOR_Y(FLOOR_Y), .X_STEP(X_STEP), .Y_STEP(Y_STEP), .DROP_PIX(DROP_PIX),
        .SPEED_LEVELS(SPEED_LEVELS)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start(start),
        .enable(enable), .speedUp(speedUp), .chgDir(chgDir), .restart(restart),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .dirRight(dirRight),
        .speedLevel(speedLevel), .landed(landed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_x = INIT_X * 64; m_y = INIT_Y * 64;
        m_cnt = 0; m_lvl = 0; m_dir = 1'b1; m_land = 1'b0;
    endtask

    // Pixel-level rules, in 1/64-pixel integers; called once per rising edge.
    task automatic model_step();
        int  spd, tgt;
        bit  land, go;
        if (!resetN || restart) begin
            model_reset();
            return;
        end
        spd = X_STEP * (m_lvl + 1);
        tgt = DROP_PIX * 64;
        if (speedUp && m_lvl < SPEED_LEVELS - 1) m_lvl++;
        if (!enable) return;
        land = (m_st != M_IDLE) && (m_st != M_LAND) && (m_y >= FLOOR_Y * 64);
        case (m_st)
            M_IDLE: if (start) begin m_st = M_MR; m_dir = 1'b1; end
            M_MR: begin
                go = (m_x >= RB * 64) || chgDir;
                if (startOfFrame) m_x = (m_x + spd > RB * 64) ? RB * 64 : m_x + spd;
                if (go) m_st = M_DL;
            end
            M_ML: begin
                go = (m_x <= LB * 64) || chgDir;
                if (startOfFrame) m_x = (m_x - spd < LB * 64) ? LB * 64 : m_x - spd;
                if (go) m_st = M_DR;
            end
            M_DL, M_DR: begin
                if (m_cnt >= tgt) begin
                    if (!land) begin
                        m_y   = m_y - m_cnt + tgt;
                        m_cnt = 0;
                        m_dir = (m_st == M_DR);
                        m_st  = (m_st == M_DL) ? M_ML : M_MR;
                    end
                end else if (startOfFrame) begin
                    m_y += Y_STEP;
                    m_cnt += Y_STEP;
                end
            end
            default: ;
        endcase
        if (land) begin m_st = M_LAND; m_land = 1'b1; end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("x",      int'(topLeftX),   m_x / 64);
            check("y",      int'(topLeftY),   m_y / 64);
            check("dir",    int'(dirRight),   int'(m_dir));
            check("level",  int'(speedLevel), m_lvl);
            check("landed", int'(landed),     int'(m_land));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; cyc();
            startOfFrame = 1'b0; cyc();
        end
    endtask

    task automatic pulse_start();   start = 1'b1;   cyc(); start = 1'b0;   endtask
    task automatic pulse_chg();     chgDir = 1'b1;  cyc(); chgDir = 1'b0;  endtask
    task automatic pulse_speed();   speedUp = 1'b1; cyc(); speedUp = 1'b0; endtask

    initial begin
        model_reset();
        repeat (3) cyc();
        chk_on = 1'b1;
        check("rst_x", int'(topLeftX), 20);
        check("rst_y", int'(topLeftY), 20);
        check("rst_dir", int'(dirRight), 1);
        check("rst_landed", int'(landed), 0);

        resetN = 1'b1; enable = 1'b1;
        pulse_start();
        frames(32);
        check("run32_x", int'(topLeftX), 60);
        check("run32_y", int'(topLeftY), 20);

        frames(432);
        check("wall_x", int'(topLeftX), 600);
        frames(16);
        check("row1_y", int'(topLeftY), 36);
        check("row1_dir", int'(dirRight), 0);

        repeat (4) pulse_speed();
        check("lvl_sat", int'(speedLevel), 3);
        frames(1);
        check("fast_x", int'(topLeftX), 595);

        frames(59);
        check("x300", int'(topLeftX), 300);
        pulse_chg();
        check("chg_x", int'(topLeftX), 300);
        pulse_chg();
        frames(16);
        check("row2_y", int'(topLeftY), 52);
        check("row2_dir", int'(dirRight), 1);

        frames(3);
        enable = 1'b0; frames(20); enable = 1'b1;
        check("frz_x", int'(topLeftX), 315);
        pulse_chg();
        frames(5);
        enable = 1'b0; frames(20); enable = 1'b1;
        check("frz_y", int'(topLeftY), 57);
        frames(11);
        check("row3_y", int'(topLeftY), 68);
        check("row3_dir", int'(dirRight), 0);

        for (int r = 0; r < 21; r++) begin
            pulse_chg();
            frames(16);
        end
        check("land_flag", int'(landed), 1);
        check("land_y", int'(topLeftY), 400);
        frames(10);
        check("land_hold_y", int'(topLeftY), 400);
        check("land_hold_x", int'(topLeftX), 315);

        restart = 1'b1; speedUp = 1'b1; cyc(); restart = 1'b0; speedUp = 1'b0;
        check("rs_x", int'(topLeftX), 20);
        check("rs_y", int'(topLeftY), 20);
        check("rs_lvl", int'(speedLevel), 0);
        check("rs_landed", int'(landed), 0);
        frames(3);
        check("idle_x", int'(topLeftX), 20);

        pulse_speed();
        pulse_start();
        pulse_chg();
        frames(5);
        check("drop_y", int'(topLeftY), 25);
        resetN = 1'b0; model_reset(); #1;
        check("arst_y", int'(topLeftY), 20);
        check("arst_lvl", int'(speedLevel), 0);
        check("arst_dir", int'(dirRight), 1);
        repeat (2) cyc();
        resetN = 1'b1;
        frames(5);
        check("post_rst_y", int'(topLeftY), 20);

        for (int i = 0; i < 8000; i++) begin
            startOfFrame = ($urandom_range(0, 2) == 0);
            start        = ($urandom_range(0, 15) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            speedUp      = ($urandom_range(0, 60) == 0);
            chgDir       = ($urandom_range(0, 150) == 0);
            restart      = ($urandom_range(0, 1500) == 0);
            if ($urandom_range(0, 2500) == 0) begin
                resetN = 1'b0;
                model_reset();
            end else begin
                resetN = 1'b1;
            end
            cyc();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
